regfile_wb_sched: RTL and testbench
===================================

Name: regfile_wb_sched

Overview:
- Write-back scheduler for the 16-entry, 64-bit register file write port.
- Four producers compete for the single write port: ALU result, immediate load, return-address (link) and memory load data. Each producer has a one-entry holding buffer.
- The block arbitrates among them and drives registered write controls (data, select, width, write strobe) into the register-file interface.
- A per-register scoreboard flags pending writes so the decoder can stall on read-after-write hazards.

Parameters:
- NSRC, 4, number of write-back sources; fixed order 0=ALU, 1=IMM, 2=RET, 3=LOAD.
- STARVE_LIM, 8, wait cycles after which a buffered request is promoted above fixed priority (range 1..255).
- DW, 64, data width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- src_valid  input  NSRC  per-source request valid.
- src_ready  output  NSRC  per-source buffer can accept.
- src_data  input  NSRC*DW  per-source write data; source i occupies bits [i*DW +: DW].
- src_sel  input  NSRC*4  per-source destination register.
- src_width  input  NSRC*2  per-source write width code, passed through unchanged.
- iss_valid  input  1  decoder issues an instruction with a destination.
- iss_sel  input  4  destination register of the issued instruction.
- rdasel, rdbsel  input  4  registers the decoder wants to read.
- rda_busy, rdb_busy  output  1  the read register has a pending write.
- wb_wr  output  1  register-file write strobe (registered).
- wb_sel  output  4  write destination (registered).
- wb_width  output  2  write width (registered).
- wb_data  output  DW  write data (registered).
- busy_vec  output  16  scoreboard contents.

Behaviour:
- Reset (reset=0 at an edge):
  - All holding buffers empty; age counters 0; scoreboard 0.
  - wb_wr=0, wb_sel=0, wb_width=0, wb_data=0; src_ready all 1 in the cycle after reset.
  - Reset mid-operation discards all buffered requests. No write is emitted on or after the reset edge.
- Acceptance:
  - Source i is accepted at an edge when src_valid[i] & src_ready[i]; data, sel and width are captured into buffer i.
  - src_ready[i] = buffer i empty OR buffer i granted this cycle. This gives back-to-back acceptance at one request per cycle per source.
- Arbitration (combinational on buffer state, one grant per cycle):
  - Starved set = occupied buffers with age >= STARVE_LIM.
  - If the starved set is non-empty, grant its lowest index. Otherwise grant the lowest-index occupied buffer (ALU > IMM > RET > LOAD).
  - A buffer loaded at edge E is first eligible for grant in the cycle after E. There is no same-cycle bypass.
- Write output:
  - At the edge ending a granting cycle: wb_wr<=1 and wb_sel/width/data <= the granted buffer; that buffer empties unless refilled at the same edge.
  - With no grant, wb_wr<=0 and the other wb_* outputs hold their previous values.
  - Latency: accept at E0, wb_wr high after E1 at minimum, register file commits at E2.
- Age counters:
  - Each occupied, non-granted buffer increments its age every cycle, saturating at 255.
  - Age clears on grant and on a new load into the buffer.
- Scoreboard:
  - iss_valid sets bit iss_sel.
  - A grant clears bit sel of the granted buffer at the same edge wb_wr is registered.
  - If an issue and a clear hit the same register in the same edge, set wins (newer producer pending).
  - rda_busy = busy_vec[rdasel]; rdb_busy = busy_vec[rdbsel]. Combinational, reflecting the current register state with no bypass of same-cycle issue.
- Duplicate destinations:
  - Two buffers targeting the same register are written in grant order.
  - The scoreboard clears on the first grant. The decoder must not issue a second producer to a busy register, so this case is illegal for hazard tracking but still written correctly.
- Width:
  - src_width is not interpreted; data is passed to the register file unmodified.

Decomposition:
- Package regfile_wb_pkg holds:
  - source index constants SRC_ALU=0, SRC_IMM=1, SRC_RET=2, SRC_LOAD=3;
  - a wb_req_t struct {data[63:0], sel[3:0], width[1:0]};
  - the width codes shared with the register file.
- One natural sub-module, wb_arb: starvation-aware fixed-priority arbiter taking occupied and starved vectors and returning a one-hot grant.
- Scoreboard and buffers stay in the top level.

Test Plan:
- Reset then single ALU request (sel=5, data=0x1234, width=3) at E0 -> wb_wr=1, wb_sel=5, wb_data=0x1234, wb_width=3 after E1; src_ready[0]=1 throughout.
- All four sources valid at the same edge -> grants in order ALU, IMM, RET, LOAD on four consecutive wb_wr pulses; LOAD age reaches 3 before its grant.
- ALU valid every cycle while LOAD is buffered, STARVE_LIM=8 -> LOAD is granted on the 9th arbitration cycle, ALU resumes the next cycle.
- iss_valid with iss_sel=7, then rdasel=7 -> rda_busy=1 until the edge the sel=7 write is granted; rda_busy=0 after. Issue to reg 7 on the same edge as that grant -> busy stays 1.
- RET buffered (sel=14) and reset=0 for one edge -> no wb_wr, busy_vec=0, all src_ready=1 after reset is released.
- Back-to-back LOAD requests with no competition -> one write per cycle and src_ready[3] stays 1.

Source files
------------

// File: rtl/regfile_wb_sched_pkg.sv
// Shared definitions for the register-file write-back scheduler: source
// indices, the buffered request record and the register-file width codes.
package regfile_wb_pkg;

  localparam int RF_DW   = 64;
  localparam int RF_NREG = 16;

  localparam int SRC_ALU  = 0;
  localparam int SRC_IMM  = 1;
  localparam int SRC_RET  = 2;
  localparam int SRC_LOAD = 3;

  typedef enum logic [1:0] {
    WB_W8  = 2'd0,
    WB_W16 = 2'd1,
    WB_W32 = 2'd2,
    WB_W64 = 2'd3
  } wb_width_e;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  sel;
    logic [1:0]  width;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Producer/decoder/register-file bundle seen by the write-back scheduler.
interface regfile_wb_sched_if #(
  parameter int NSRC = 4,
  parameter int DW   = 64
);

  logic [NSRC-1:0]    src_valid;
  logic [NSRC-1:0]    src_ready;
  logic [NSRC*DW-1:0] src_data;
  logic [NSRC*4-1:0]  src_sel;
  logic [NSRC*2-1:0]  src_width;

  logic               iss_valid;
  logic [3:0]         iss_sel;
  logic [3:0]         rdasel;
  logic [3:0]         rdbsel;
  logic               rda_busy;
  logic               rdb_busy;

  logic               wb_wr;
  logic [3:0]         wb_sel;
  logic [1:0]         wb_width;
  logic [DW-1:0]      wb_data;
  logic [15:0]        busy_vec;

  modport master (
    output src_valid, src_data, src_sel, src_width,
    output iss_valid, iss_sel, rdasel, rdbsel,
    input  src_ready, rda_busy, rdb_busy,
    input  wb_wr, wb_sel, wb_width, wb_data, busy_vec
  );

  modport slave (
    input  src_valid, src_data, src_sel, src_width,
    input  iss_valid, iss_sel, rdasel, rdbsel,
    output src_ready, rda_busy, rdb_busy,
    output wb_wr, wb_sel, wb_width, wb_data, busy_vec
  );

endinterface

// File: rtl/regfile_wb_sched_arb.sv
// Starvation-aware fixed-priority arbiter: lowest starved index wins,
// otherwise lowest occupied index. Output is one-hot or zero.
module wb_arb #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] occ_i,
  input  logic [NSRC-1:0] starved_i,
  output logic [NSRC-1:0] grant_o
);

  logic [NSRC-1:0] pool;

  assign pool = (|starved_i) ? starved_i : occ_i;
  // Isolate the lowest set bit.
  assign grant_o = pool & (~pool + NSRC'(1));

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: per-source holding buffers, starvation-aware
// arbitration onto the single register-file write port, RAW scoreboard.
module regfile_wb_sched
  import regfile_wb_pkg::*;
#(
  parameter int NSRC       = 4,
  parameter int STARVE_LIM = 8,
  parameter int DW         = RF_DW
) (
  input logic               clk,
  input logic               reset,
  regfile_wb_sched_if.slave bus
);

  localparam logic [7:0] STARVE_LIM_W = 8'(STARVE_LIM);

  function automatic logic [7:0] age_sat_inc(input logic [7:0] a);
    return (a == 8'hFF) ? a : a + 8'd1;
  endfunction

  logic [NSRC-1:0] occ_q, occ_d;
  logic [NSRC-1:0] starved, grant, ready, accept;
  wb_req_t         buf_q [NSRC];
  wb_req_t         buf_d [NSRC];
  logic [7:0]      age_q [NSRC];
  logic [7:0]      age_d [NSRC];
  wb_req_t         gnt_req;
  logic            wr_q, wr_d;
  wb_req_t         out_q, out_d;
  logic [15:0]     busy_q, busy_d;

  always_comb begin
    starved = '0;
    for (int i = 0; i < NSRC; i++) begin
      starved[i] = occ_q[i] && (age_q[i] >= STARVE_LIM_W);
    end
  end

  wb_arb #(.NSRC(NSRC)) u_arb (
    .occ_i     (occ_q),
    .starved_i (starved),
    .grant_o   (grant)
  );

  // A buffer being drained this cycle can be refilled at the same edge.
  assign ready  = ~occ_q | grant;
  assign accept = bus.src_valid & ready;

  always_comb begin
    gnt_req = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant[i]) gnt_req = buf_q[i];
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < NSRC; i++) begin
      occ_d[i] = occ_q[i] & ~grant[i];
      buf_d[i] = buf_q[i];
      age_d[i] = (occ_q[i] & ~grant[i]) ? age_sat_inc(age_q[i]) : 8'd0;
      if (accept[i]) begin
        occ_d[i]       = 1'b1;
        buf_d[i].data  = bus.src_data[i*DW +: DW];
        buf_d[i].sel   = bus.src_sel[i*4 +: 4];
        buf_d[i].width = bus.src_width[i*2 +: 2];
        age_d[i]       = 8'd0;
      end
    end
  end

  always_comb begin
    wr_d  = |grant;
    out_d = wr_d ? gnt_req : out_q;
  end

  // Issue is applied after the clear so a same-edge re-issue stays pending.
  always_comb begin
    busy_d = busy_q;
    if (|grant)        busy_d[gnt_req.sel] = 1'b0;
    if (bus.iss_valid) busy_d[bus.iss_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      occ_q  <= '0;
      wr_q   <= 1'b0;
      out_q  <= '0;
      busy_q <= '0;
      for (int i = 0; i < NSRC; i++) age_q[i] <= 8'd0;
    end else begin
      occ_q  <= occ_d;
      wr_q   <= wr_d;
      out_q  <= out_d;
      busy_q <= busy_d;
      for (int i = 0; i < NSRC; i++) age_q[i] <= age_d[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) buf_q[i] <= buf_d[i];
  end

  assign bus.src_ready = ready;
  assign bus.wb_wr     = wr_q;
  assign bus.wb_sel    = out_q.sel;
  assign bus.wb_width  = out_q.width;
  assign bus.wb_data   = out_q.data;
  assign bus.busy_vec  = busy_q;
  assign bus.rda_busy  = busy_q[bus.rdasel];
  assign bus.rdb_busy  = busy_q[bus.rdbsel];

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched with hand-computed expectations.
module tb_regfile_wb_sched;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  regfile_wb_sched_if #(.NSRC(4), .DW(64)) bus ();

  regfile_wb_sched #(.NSRC(4), .STARVE_LIM(8), .DW(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [3:0] sel, input logic [63:0] data,
                         input logic [1:0] w);
    bus.src_valid[i]          = 1'b1;
    bus.src_sel[i*4 +: 4]     = sel;
    bus.src_data[i*64 +: 64]  = data;
    bus.src_width[i*2 +: 2]   = w;
  endtask

  task automatic check_wb(input string tag, input logic [3:0] sel, input logic [63:0] data);
    check({tag, "_wr"},   64'(bus.wb_wr),  64'd1);
    check({tag, "_sel"},  64'(bus.wb_sel), 64'(sel));
    check({tag, "_data"}, bus.wb_data,     data);
  endtask

  initial begin
    reset         = 1'b0;
    bus.src_valid = '0;
    bus.src_data  = '0;
    bus.src_sel   = '0;
    bus.src_width = '0;
    bus.iss_valid = 1'b0;
    bus.iss_sel   = '0;
    bus.rdasel    = '0;
    bus.rdbsel    = '0;

    tick();
    tick();
    check("rst_wr",    64'(bus.wb_wr),     64'd0);
    check("rst_sel",   64'(bus.wb_sel),    64'd0);
    check("rst_width", 64'(bus.wb_width),  64'd0);
    check("rst_data",  bus.wb_data,        64'd0);
    check("rst_busy",  64'(bus.busy_vec),  64'd0);
    reset = 1'b1;
    check("rst_ready", 64'(bus.src_ready), 64'hF);

    // Single ALU request
    set_src(0, 4'd5, 64'h1234, 2'd3);
    tick();
    bus.src_valid = '0;
    check("alu_wr_e0",   64'(bus.wb_wr),        64'd0);
    check("alu_rdy_e0",  64'(bus.src_ready[0]), 64'd1);
    tick();
    check_wb("alu", 4'd5, 64'h1234);
    check("alu_width",   64'(bus.wb_width),     64'd3);
    tick();
    check("alu_wr_off",  64'(bus.wb_wr),        64'd0);
    check("alu_sel_hold",64'(bus.wb_sel),       64'd5);

    // All four sources at once: fixed-priority order
    for (int i = 0; i < 4; i++) set_src(i, 4'(i + 1), 64'hA0 + 64'(i), 2'(i));
    tick();
    bus.src_valid = '0;
    check("all_rdy_e0", 64'(bus.src_ready), 64'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_wb($sformatf("all%0d", i), 4'(i + 1), 64'hA0 + 64'(i));
      check($sformatf("all%0d_w", i), 64'(bus.wb_width), 64'(i));
    end
    tick();
    check("all_wr_off", 64'(bus.wb_wr), 64'd0);

    // Starvation: LOAD waits behind a continuously busy ALU
    set_src(3, 4'd9, 64'h99, 2'd2);
    for (int k = 0; k <= 8; k++) begin
      set_src(0, 4'd1, 64'h100 + 64'(k), 2'd3);
      tick();
      if (k == 0) bus.src_valid[3] = 1'b0;
      else check_wb($sformatf("stv%0d", k), 4'd1, 64'h100 + 64'(k - 1));
    end
    set_src(0, 4'd1, 64'h109, 2'd3);
    tick();
    check_wb("stv_load", 4'd9, 64'h99);
    bus.src_valid = '0;
    tick();
    check_wb("stv_resume", 4'd1, 64'h108);
    tick();
    check("stv_wr_off", 64'(bus.wb_wr), 64'd0);

    // Scoreboard set/clear and set-wins-over-clear
    bus.iss_valid = 1'b1;
    bus.iss_sel   = 4'd7;
    bus.rdasel    = 4'd7;
    bus.rdbsel    = 4'd3;
    check("sb_nobypass", 64'(bus.rda_busy), 64'd0);
    tick();
    bus.iss_valid = 1'b0;
    check("sb_set_a",  64'(bus.rda_busy), 64'd1);
    check("sb_set_b",  64'(bus.rdb_busy), 64'd0);
    check("sb_vec",    64'(bus.busy_vec), 64'h0080);
    set_src(2, 4'd7, 64'h77, 2'd1);
    tick();
    bus.src_valid = '0;
    check("sb_pend",   64'(bus.rda_busy), 64'd1);
    tick();
    check_wb("sb_wb", 4'd7, 64'h77);
    check("sb_clr",    64'(bus.rda_busy), 64'd0);
    check("sb_clrvec", 64'(bus.busy_vec), 64'h0);
    set_src(2, 4'd7, 64'h78, 2'd1);
    bus.iss_valid = 1'b1;
    tick();
    bus.src_valid = '0;
    check("sb_reset_a", 64'(bus.rda_busy), 64'd1);
    tick();
    bus.iss_valid = 1'b0;
    check_wb("sb_wb2", 4'd7, 64'h78);
    check("sb_setwins", 64'(bus.rda_busy), 64'd1);

    // Reset while RET is buffered
    set_src(2, 4'd14, 64'hEE, 2'd0);
    tick();
    bus.src_valid = '0;
    reset = 1'b0;
    tick();
    check("mid_rst_wr",   64'(bus.wb_wr),    64'd0);
    check("mid_rst_busy", 64'(bus.busy_vec), 64'd0);
    reset = 1'b1;
    check("mid_rst_rdy",  64'(bus.src_ready), 64'hF);
    tick();
    check("mid_rst_wr2",  64'(bus.wb_wr),    64'd0);
    check("mid_rst_sel",  64'(bus.wb_sel),   64'd0);

    // Back-to-back LOAD requests
    for (int k = 0; k < 5; k++) begin
      set_src(3, 4'd12, 64'h500 + 64'(k), 2'd3);
      check($sformatf("b2b_rdy%0d", k), 64'(bus.src_ready[3]), 64'd1);
      tick();
      if (k > 0) check_wb($sformatf("b2b%0d", k), 4'd12, 64'h500 + 64'(k - 1));
    end
    bus.src_valid = '0;
    tick();
    check_wb("b2b_last", 4'd12, 64'h504);
    tick();
    check("b2b_wr_off", 64'(bus.wb_wr), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
